// File: rtl/div_unit_pkg.sv
// Shared constants for the multi-cycle divider and the EX stage that drives it:
// FSM state codes, handshake levels, ALU op codes and the HI/LO bus width.
package div_unit_pkg;

  localparam int DIV_DATA_W = 32;
  localparam int DOUBLE_REG_BUS_W = 2 * DIV_DATA_W;

  // Divider FSM state codes (2-bit, legacy encoding shared with the EX stage)
  localparam logic [1:0] DIV_FREE    = 2'b00;
  localparam logic [1:0] DIV_BY_ZERO = 2'b01;
  localparam logic [1:0] DIV_ON      = 2'b10;
  localparam logic [1:0] DIV_END     = 2'b11;

  // Handshake levels as seen by the EX stage
  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;
  localparam logic DIV_START            = 1'b1;
  localparam logic DIV_STOP             = 1'b0;

  // ALU op codes that route an instruction to the divider
  localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

endpackage

// File: rtl/div_unit.sv
// Multi-cycle restoring divider for DIV/DIVU. EX holds start_i until it has
// consumed ready_o; the result is {remainder, quotient} for HI/LO.
// One quotient bit per clock on operand magnitudes, sign fixup on the last step.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int DATA_W = DIV_DATA_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  signed_div_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  input  logic                  start_i,
  input  logic                  annul_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o
);

  localparam logic [5:0] LAST_CNT = 6'(DATA_W - 1);

  logic [1:0]          state;
  logic [5:0]          cnt;
  logic [2*DATA_W:0]   work;          // {partial remainder (33b), dividend/quotient (32b)}
  logic [DATA_W-1:0]   divisor_mag;
  logic                dividend_neg;
  logic                quotient_neg;

  logic                op1_neg;
  logic                op2_neg;
  logic [DATA_W-1:0]   op1_mag;
  logic [DATA_W-1:0]   op2_mag;

  logic [2*DATA_W+1:0] shifted;
  logic [DATA_W+1:0]   trial;
  logic [2*DATA_W:0]   step_work;
  logic [DATA_W-1:0]   quot_fix;
  logic [DATA_W-1:0]   rem_fix;

  // Operand magnitudes and signs; 0x80000000 maps onto itself as an unsigned magnitude
  always_comb begin
    op1_neg = signed_div_i & opdata1_i[DATA_W-1];
    op2_neg = signed_div_i & opdata2_i[DATA_W-1];
    op1_mag = op1_neg ? ({DATA_W{1'b0}} - opdata1_i) : opdata1_i;
    op2_mag = op2_neg ? ({DATA_W{1'b0}} - opdata2_i) : opdata2_i;
  end

  // One restoring step: shift left, trial-subtract the divisor from the upper bits
  always_comb begin
    // NOTE: every always_comb output gets a value on every path (here by
    // unconditional first assignments), otherwise synthesis infers a latch.
    shifted   = {work, 1'b0};
    trial     = shifted[2*DATA_W+1:DATA_W] - {2'b00, divisor_mag};
    step_work = shifted[2*DATA_W:0];
    if (!trial[DATA_W+1]) begin
      step_work = {trial[DATA_W:0], shifted[DATA_W-1:1], 1'b1};
    end
  end

  // Sign fixup of the final step: quotient takes sign1^sign2, remainder the dividend's sign
  always_comb begin
    quot_fix = step_work[DATA_W-1:0];
    rem_fix  = step_work[2*DATA_W-1:DATA_W];
    if (quotient_neg) begin
      quot_fix = {DATA_W{1'b0}} - step_work[DATA_W-1:0];
    end
    if (dividend_neg) begin
      rem_fix = {DATA_W{1'b0}} - step_work[2*DATA_W-1:DATA_W];
    end
  end

  // Divider FSM, working register and registered result/ready outputs
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state        <= DIV_FREE;
      cnt          <= 6'd0;
      work         <= '0;
      divisor_mag  <= '0;
      dividend_neg <= 1'b0;
      quotient_neg <= 1'b0;
      result_o     <= '0;
      ready_o      <= DIV_RESULT_NOT_READY;
    end else begin
      case (state)
        DIV_FREE: begin
          result_o <= '0;
          ready_o  <= DIV_RESULT_NOT_READY;
          if (start_i == DIV_START && !annul_i) begin
            if (opdata2_i == '0) begin
              state <= DIV_BY_ZERO;
            end else begin
              state        <= DIV_ON;
              cnt          <= 6'd0;
              work         <= {{(DATA_W+1){1'b0}}, op1_mag};
              divisor_mag  <= op2_mag;
              dividend_neg <= op1_neg;
              quotient_neg <= op1_neg ^ op2_neg;
            end
          end
        end

        DIV_BY_ZERO: begin
          state    <= DIV_END;
          result_o <= '0;
          ready_o  <= DIV_RESULT_READY;
        end

        DIV_ON: begin
          if (annul_i) begin
            state    <= DIV_FREE;
            cnt      <= 6'd0;
            result_o <= '0;
            ready_o  <= DIV_RESULT_NOT_READY;
          end else begin
            work <= step_work;
            cnt  <= cnt + 6'd1;
            // The final quotient bit, the fixup and the result load share one edge
            if (cnt == LAST_CNT) begin
              state    <= DIV_END;
              result_o <= {rem_fix, quot_fix};
              ready_o  <= DIV_RESULT_READY;
            end
          end
        end

        DIV_END: begin
          if (start_i == DIV_STOP) begin
            state    <= DIV_FREE;
            cnt      <= 6'd0;
            result_o <= '0;
            ready_o  <= DIV_RESULT_NOT_READY;
          end
        end

        default: begin
          state    <= DIV_FREE;
          result_o <= '0;
          ready_o  <= DIV_RESULT_NOT_READY;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed corner cases, annul, reset and
// randomized operands against an arithmetic reference model.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        signed_div = 1'b0;
  logic [31:0] op1 = '0;
  logic [31:0] op2 = '0;
  logic        start = 1'b0;
  logic        annul = 1'b0;
  logic [63:0] result;
  logic        ready;

  int compared   = 0;
  int mismatched = 0;

  div_unit #(.DATA_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div),
    .opdata1_i    (op1),
    .opdata2_i    (op2),
    .start_i      (start),
    .annul_i      (annul),
    .result_o     (result),
    .ready_o      (ready)
  );

  always #5 clk = ~clk;

  // Reference: plain integer division, truncating toward zero, {remainder, quotient}
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                          input logic sgn);
    longint q;
    longint r;
    longint unsigned uq;
    longint unsigned ur;
    if (b == 32'd0) return 64'd0;
    if (sgn) begin
      q = longint'($signed(a)) / longint'($signed(b));
      r = longint'($signed(a)) % longint'($signed(b));
      return {r[31:0], q[31:0]};
    end
    uq = longint'({32'd0, a}) / longint'({32'd0, b});
    ur = longint'({32'd0, a}) % longint'({32'd0, b});
    return {ur[31:0], uq[31:0]};
  endfunction

  task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Full transaction from a negedge: accept, measure latency, hold, release
  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                         input string tag);
    logic [63:0] exp;
    int edges;
    int want;
    exp        = ref_div(a, b, sgn);
    want       = (b == 32'd0) ? 2 : 33;
    signed_div = sgn;
    op1        = a;
    op2        = b;
    annul      = 1'b0;
    start      = 1'b1;
    edges      = 0;
    while (edges < 100) begin
      @(negedge clk);
      edges++;
      if (edges == 1) begin
        op1        = $urandom;
        op2        = $urandom;
        signed_div = 1'($urandom_range(0, 1));
      end
      if (ready) break;
    end
    check({tag, " latency"}, 65'(edges), 65'(want));
    check({tag, " result"}, {ready, result}, {1'b1, exp});
    repeat (3) @(negedge clk);
    check({tag, " held"}, {ready, result}, {1'b1, exp});
    start = 1'b0;
    @(negedge clk);
    check({tag, " drop"}, {ready, result}, 65'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        saw;
    logic [31:0] a;
    logic [31:0] b;
    logic        sgn;

    // Asynchronous reset before any clock edge
    #2 rst = 1'b1;
    #1 check("reset outputs", {ready, result}, 65'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("post reset", {ready, result}, 65'd0);

    // Directed cases
    run_div(32'd100,        32'd7,          1'b0, "udiv 100/7");
    run_div(32'hFFFF_FFF9,  32'h0000_0002,  1'b1, "sdiv -7/2");
    run_div(32'h0000_0007,  32'hFFFF_FFFE,  1'b1, "sdiv 7/-2");
    run_div(32'h8000_0000,  32'hFFFF_FFFF,  1'b1, "sdiv overflow");
    run_div(32'hFFFF_FFFF,  32'h0000_0001,  1'b0, "udiv max/1");
    run_div(32'h1234_5678,  32'd0,          1'b1, "div by zero");
    run_div(32'd0,          32'd0,          1'b0, "zero by zero");

    // Annul at cnt=10, with start still high, then again in FREE
    signed_div = 1'b0;
    op1        = 32'h1234_5678;
    op2        = 32'd3;
    start      = 1'b1;
    repeat (11) @(negedge clk);
    check("annul busy", {ready, result}, 65'd0);
    annul = 1'b1;
    @(negedge clk);
    check("annul to free", {ready, result}, 65'd0);
    @(negedge clk);
    annul = 1'b0;
    start = 1'b0;
    saw   = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (ready) saw = 1'b1;
    end
    check("annul no result", 65'(saw), 65'd0);
    run_div(32'd9, 32'd3, 1'b0, "after annul");

    // Reset at cnt=20 aborts with no residue
    op1   = 32'hDEAD_BEEF;
    op2   = 32'd5;
    start = 1'b1;
    repeat (21) @(negedge clk);
    rst = 1'b1;
    #1 check("reset mid div", {ready, result}, 65'd0);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    saw = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (ready) saw = 1'b1;
    end
    check("reset no result", 65'(saw), 65'd0);
    run_div(32'd1000, 32'd10, 1'b0, "after reset");

    // Reset while a result is presented clears outputs immediately
    op1   = 32'd100;
    op2   = 32'd7;
    start = 1'b1;
    repeat (34) @(negedge clk);
    check("end before reset", {ready, result}, {1'b1, 32'd2, 32'd14});
    #2 rst = 1'b1;
    #1 check("async reset in end", {ready, result}, 65'd0);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("idle after reset", {ready, result}, 65'd0);

    // Randomized operands
    for (int i = 0; i < 24; i++) begin
      a   = $urandom;
      sgn = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 5) == 0) a = 32'h8000_0000;
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1:       b = 32'd1;
        2:       b = 32'hFFFF_FFFF;
        3:       b = 32'($urandom_range(1, 15));
        4:       b = 32'h8000_0000;
        default: b = $urandom;
      endcase
      run_div(a, b, sgn, $sformatf("rand%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
